// File: rtl/msdf_pkg.sv
// Shared definitions for the MSDF multiplier sequencer: digit codes, FSM states, defaults.
// Optional abort support in msdf_mult_seq is enabled with `define MSDF_SEQ_ABORT_EN.
package msdf_pkg;

   localparam int NDIG_DEF  = 8;
   localparam int DELTA_DEF = 3;

   localparam logic [1:0] DIG_POS  = 2'b10;
   localparam logic [1:0] DIG_NEG  = 2'b01;
   localparam logic [1:0] DIG_ZERO = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLR   = 3'd1,
      ST_FEED  = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DONE  = 3'd4
   } seq_state_e;

   // The redundant zero code 2'b11 is folded to 2'b00 so it never reaches the multiplier.
   function automatic logic [1:0] dig_clean(input logic [1:0] d);
      logic [1:0] r;
      if (d == 2'b11) begin
         r = DIG_ZERO;
      end else begin
         r = d;
      end
      return r;
   endfunction

endpackage

// File: rtl/msdf_digit_shreg.sv
// MSD-first radix-2 signed-digit shift register with parallel load.
// Shifts left by one digit per enabled cycle, inserting din at the LSD position.
module msdf_digit_shreg
   import msdf_pkg::*;
#(
   parameter int NDIG = NDIG_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [2*NDIG-1:0] load_val,
   input  logic              shift,
   input  logic [1:0]        din,
   output logic [2*NDIG-1:0] q,
   output logic [2*NDIG-1:0] nxt,
   output logic [1:0]        msd
);

   logic [2*NDIG-1:0] word_q;
   logic [2*NDIG-1:0] word_d;

   // Load has priority over shift.
   always_comb begin
      word_d = word_q;
      if (load) begin
         word_d = load_val;
      end else if (shift) begin
         word_d = {word_q[2*NDIG-3:0], din};
      end else begin
         word_d = word_q;
      end
   end

   // Digit storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q <= '0;
      end else begin
         word_q <= word_d;
      end
   end

   assign q   = word_q;
   assign nxt = word_d;
   assign msd = word_q[2*NDIG-1 -: 2];

endmodule

// File: rtl/msdf_mult_seq.sv
// Sequencer for the online MSDF multiplier: operand streaming, delay drain, result assembly.
// Define MSDF_SEQ_ABORT_EN to add the abort input.
module msdf_mult_seq
   import msdf_pkg::*;
#(
   parameter int NDIG  = NDIG_DEF,
   parameter int DELTA = DELTA_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2*NDIG-1:0] x_in,
   input  logic [2*NDIG-1:0] y_in,
`ifdef MSDF_SEQ_ABORT_EN
   input  logic              abort,
`endif
   output logic              busy,
   output logic              done,
   output logic [2*NDIG-1:0] p_out,
   output logic              m_rst,
   output logic [1:0]        m_xi,
   output logic [1:0]        m_yi,
   output logic              m_valid,
   output logic              m_valid2,
   output logic              m_valid3,
   input  logic [1:0]        m_p
);

   localparam int CW = $clog2(NDIG + DELTA + 1);
   localparam logic [CW-1:0] FEED_LAST  = CW'(NDIG - 1);
   localparam logic [CW-1:0] FLUSH_LAST = CW'(NDIG + DELTA - 1);
   localparam logic [CW-1:0] CAP_FIRST  = CW'(DELTA);
   localparam logic [CW-1:0] CAP_LAST   = CW'(DELTA + NDIG - 1);

   seq_state_e        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              m_rst_q, m_rst_d;
   logic              m_valid_q, m_valid_d;
   logic              m_valid2_q, m_valid3_q;
   logic [1:0]        m_xi_q, m_xi_d;
   logic [1:0]        m_yi_q, m_yi_d;
   logic [2*NDIG-1:0] p_out_q, p_out_d;

   logic              abort_hit;
   logic              accept;
   logic              op_load;
   logic [2*NDIG-1:0] x_load_val, y_load_val;
   logic              op_shift;
   logic              cap_load, cap_shift;
   logic [1:0]        x_msd, y_msd;
   logic [2*NDIG-1:0] cap_nxt;
   logic [2*NDIG-1:0] x_word_unused, y_word_unused, x_nxt_unused, y_nxt_unused;
   logic [2*NDIG-1:0] cap_word_unused;
   logic [1:0]        cap_msd_unused;

   assign accept = (state_q == ST_IDLE) && start;

`ifdef MSDF_SEQ_ABORT_EN
   assign abort_hit = abort && ((state_q == ST_CLR) || (state_q == ST_FEED) || (state_q == ST_FLUSH));
`else
   assign abort_hit = 1'b0;
`endif

   // Next state and digit counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (abort_hit) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_CLR;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_CLR: begin
               state_d = ST_FEED;
               cnt_d   = '0;
            end
            ST_FEED: begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == FEED_LAST) begin
                  state_d = ST_FLUSH;
               end else begin
                  state_d = ST_FEED;
               end
            end
            ST_FLUSH: begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == FLUSH_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_FLUSH;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Operand registers are zeroed on abort so no stale digits survive.
   assign op_load    = accept || abort_hit;
   assign x_load_val = abort_hit ? '0 : x_in;
   assign y_load_val = abort_hit ? '0 : y_in;
   assign op_shift   = (state_d == ST_FEED);

   // Product digit c-DELTA arrives while the counter shows c.
   assign cap_load  = (state_d == ST_CLR);
   assign cap_shift = ((state_q == ST_FEED) || (state_q == ST_FLUSH)) && !abort_hit &&
                      (cnt_q >= CAP_FIRST) && (cnt_q <= CAP_LAST);

   msdf_digit_shreg #(.NDIG(NDIG)) u_x_shreg (
      .clk(clk), .rst(reset), .load(op_load), .load_val(x_load_val), .shift(op_shift),
      .din(DIG_ZERO), .q(x_word_unused), .nxt(x_nxt_unused), .msd(x_msd)
   );

   msdf_digit_shreg #(.NDIG(NDIG)) u_y_shreg (
      .clk(clk), .rst(reset), .load(op_load), .load_val(y_load_val), .shift(op_shift),
      .din(DIG_ZERO), .q(y_word_unused), .nxt(y_nxt_unused), .msd(y_msd)
   );

   msdf_digit_shreg #(.NDIG(NDIG)) u_cap_shreg (
      .clk(clk), .rst(reset), .load(cap_load), .load_val({(2*NDIG){1'b0}}), .shift(cap_shift),
      .din(m_p), .q(cap_word_unused), .nxt(cap_nxt), .msd(cap_msd_unused)
   );

   // Registered outputs, all derived from the state being entered.
   always_comb begin
      busy_d    = (state_d != ST_IDLE);
      done_d    = (state_d == ST_DONE);
      m_rst_d   = (state_d == ST_CLR) || abort_hit;
      m_valid_d = (state_d == ST_FEED) || (state_d == ST_FLUSH);
      m_xi_d    = DIG_ZERO;
      m_yi_d    = DIG_ZERO;
      p_out_d   = p_out_q;
      if (state_d == ST_FEED) begin
         m_xi_d = dig_clean(x_msd);
         m_yi_d = dig_clean(y_msd);
      end else begin
         m_xi_d = DIG_ZERO;
         m_yi_d = DIG_ZERO;
      end
      if ((state_d == ST_DONE) && (state_q == ST_FLUSH)) begin
         p_out_d = cap_nxt;
      end else begin
         p_out_d = p_out_q;
      end
   end

   // State, counter and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         m_rst_q    <= 1'b0;
         m_valid_q  <= 1'b0;
         m_valid2_q <= 1'b0;
         m_valid3_q <= 1'b0;
         m_xi_q     <= DIG_ZERO;
         m_yi_q     <= DIG_ZERO;
         p_out_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         m_rst_q    <= m_rst_d;
         m_valid_q  <= m_valid_d;
         m_valid2_q <= m_valid_q;
         m_valid3_q <= m_valid2_q;
         m_xi_q     <= m_xi_d;
         m_yi_q     <= m_yi_d;
         p_out_q    <= p_out_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign m_rst    = m_rst_q;
   assign m_valid  = m_valid_q;
   assign m_valid2 = m_valid2_q;
   assign m_valid3 = m_valid3_q;
   assign m_xi     = m_xi_q;
   assign m_yi     = m_yi_q;
   assign p_out    = p_out_q;

endmodule

// File: tb/tb_msdf_mult_seq.sv
// Self-checking bench for msdf_mult_seq; a behavioural multiplier supplies truncated product digits.
// Abort scenarios are exercised when MSDF_SEQ_ABORT_EN is defined.
module tb_msdf_mult_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] x_in, y_in;
   logic        busy, done;
   logic [15:0] p_out;
   logic        m_rst;
   logic [1:0]  m_xi, m_yi;
   logic        m_valid, m_valid2, m_valid3;
   logic [1:0]  m_p;
`ifdef MSDF_SEQ_ABORT_EN
   logic        abort;
`endif

   int          n_pass;
   int          n_total;
   logic [15:0] last_p;

   msdf_mult_seq dut (
      .clk(clk), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
`ifdef MSDF_SEQ_ABORT_EN
      .abort(abort),
`endif
      .busy(busy), .done(done), .p_out(p_out), .m_rst(m_rst), .m_xi(m_xi), .m_yi(m_yi),
      .m_valid(m_valid), .m_valid2(m_valid2), .m_valid3(m_valid3), .m_p(m_p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Numeric value of an 8-digit word, scaled by 2^8.
   function automatic int word_val(input logic [15:0] w);
      int s;
      logic [1:0] d;
      s = 0;
      for (int i = 0; i < 8; i++) begin
         d = w[15-2*i -: 2];
         if (d == 2'b10) s = s + (1 << (7 - i));
         else if (d == 2'b01) s = s - (1 << (7 - i));
      end
      return s;
   endfunction

   function automatic bit in_win(input int c, input int lo, input int hi);
      return (c >= lo) && (c <= hi);
   endfunction

   function automatic logic [15:0] rand_word();
      logic [15:0] w;
      int r;
      w = 16'h0000;
      for (int i = 0; i < 8; i++) begin
         r = $urandom_range(0, 2);
         w[15-2*i -: 2] = (r == 1) ? 2'b10 : ((r == 2) ? 2'b01 : 2'b00);
      end
      return w;
   endfunction

   // One operation; cycle n is the interval after the n-th edge following acceptance (edge 0).
   task automatic run_op(input logic [15:0] x, input logic [15:0] y, input int poke_cyc, input int abort_cyc);
      int xv, yv, pv, mag, busy_end, valid_end, err;
      bit ab;
      logic [15:0] exp_w;
      logic [1:0] ex, ey;
      ab = (abort_cyc > 0);
      xv = word_val(x);
      yv = word_val(y);
      pv = (xv * yv) / 256;
      mag = (pv < 0) ? -pv : pv;
      exp_w = 16'h0000;
      for (int i = 0; i < 8; i++)
         if (mag[7-i]) exp_w[15-2*i -: 2] = (pv < 0) ? 2'b01 : 2'b10;
      busy_end  = ab ? abort_cyc : 13;
      valid_end = ab ? abort_cyc : 12;
      @(negedge clk);
      x_in = x; y_in = y; start = 1'b1;
      @(posedge clk);
      #1;
      for (int cyc = 1; cyc <= 15; cyc++) begin
         start = 1'b0;
`ifdef MSDF_SEQ_ABORT_EN
         abort = 1'b0;
`endif
         chk($sformatf("busy@%0d", cyc), 32'(busy), 32'(cyc <= busy_end));
         chk($sformatf("done@%0d", cyc), 32'(done), 32'(!ab && cyc == 13));
         chk($sformatf("m_valid@%0d", cyc), 32'(m_valid), 32'(in_win(cyc, 2, valid_end)));
         chk($sformatf("m_valid2@%0d", cyc), 32'(m_valid2), 32'(in_win(cyc - 1, 2, valid_end)));
         chk($sformatf("m_valid3@%0d", cyc), 32'(m_valid3), 32'(in_win(cyc - 2, 2, valid_end)));
         chk($sformatf("m_rst@%0d", cyc), 32'(m_rst), 32'(cyc == 1 || (ab && cyc == abort_cyc + 1)));
         ex = 2'b00; ey = 2'b00;
         if (cyc >= 2 && cyc <= 9 && cyc <= valid_end) begin
            ex = x[15-2*(cyc-2) -: 2];
            ey = y[15-2*(cyc-2) -: 2];
         end
         chk($sformatf("m_xi@%0d", cyc), 32'(m_xi), 32'(ex));
         chk($sformatf("m_yi@%0d", cyc), 32'(m_yi), 32'(ey));
         if (!ab && cyc >= 13) chk($sformatf("p_out@%0d", cyc), 32'(p_out), 32'(exp_w));
         else if (ab || cyc <= 5) chk($sformatf("p_hold@%0d", cyc), 32'(p_out), 32'(last_p));
         if (cyc >= 5 && cyc <= 12) m_p = exp_w[15-2*(cyc-5) -: 2];
         else m_p = 2'($urandom_range(0, 3));
         if (cyc == poke_cyc) begin
            start = 1'b1;
            x_in = ~x;
         end
`ifdef MSDF_SEQ_ABORT_EN
         if (cyc == abort_cyc) abort = 1'b1;
`endif
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      if (!ab) begin
         err = word_val(p_out) * 256 - xv * yv;
         if (err < 0) err = -err;
         chk("p_numeric", 32'(err < 256), 32'd1);
         last_p = exp_w;
      end
   endtask

   initial begin
      n_pass = 0; n_total = 0; last_p = 16'h0000;
      reset = 1'b1; start = 1'b0; x_in = 16'h0000; y_in = 16'h0000; m_p = 2'b00;
`ifdef MSDF_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("idle@%0d", k),
             32'({busy, done, m_rst, m_valid, m_valid2, m_valid3, m_xi, m_yi, p_out}), 32'd0);
      end

      run_op(16'h8000, 16'h8000, 0, 0);
      run_op(16'h9200, 16'h4000, 0, 0);
      chk("mixed_val", 32'(word_val(p_out)), 32'(-40));
      run_op(rand_word(), rand_word(), 6, 0);
      run_op(rand_word(), rand_word(), 13, 0);
      for (int n = 0; n < 4; n++) run_op(rand_word(), rand_word(), 0, 0);

      @(negedge clk);
      x_in = rand_word(); y_in = rand_word(); start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      chk("busy_in_feed", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("reset_abort",
          32'({busy, done, m_rst, m_valid, m_valid2, m_valid3, m_xi, m_yi, p_out}), 32'd0);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("reset_nodone@%0d", k), 32'({busy, done}), 32'd0);
      end
      @(negedge clk);
      reset = 1'b0;
      last_p = 16'h0000;
      run_op(rand_word(), rand_word(), 0, 0);

`ifdef MSDF_SEQ_ABORT_EN
      run_op(rand_word(), rand_word(), 0, 11);
      run_op(rand_word(), rand_word(), 0, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
